// File: rtl/core_seq.sv
// core_seq: tile sequencer that emits the core instruction word for WS/OS runs.
// Defining CORE_SEQ_OS_EN adds the output-stationary path; without it only WS exists.
module core_seq #(
  parameter int  ROW    = 8,
  parameter int  COL    = 8,
  parameter int  ADDR_W = 11,
  parameter int  CNT_W  = 11,
  localparam int INST_W = 2*ADDR_W+12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_act,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int KW = $clog2(ROW+COL+1);
  localparam int CW = (CNT_W > KW) ? CNT_W : KW;

  localparam logic [CW-1:0]     ROW_C   = CW'(ROW);
  localparam logic [CW-1:0]     KLAST_C = CW'(ROW+COL-1);
  localparam logic [CW-1:0]     ONE_C   = CW'(1'b1);
  localparam logic [ADDR_W-1:0] ROW_A   = ADDR_W'(ROW);
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [INST_W-1:0] IDLE_WORD = {1'b0, 1'b1, 1'b1, ZERO_A, 1'b1, 1'b1, ZERO_A, 7'b0000000};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    KLOAD = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r, state_nx_s;
  logic [CW-1:0]     cnt_r, cnt_nx_s;
  logic [CW-1:0]     j_r, j_nx_s;
  logic              rd_r, rd_nx_s;
  logic              wr_r, wr_nx_s;
  logic              mode_r, mode_nx_s, mode_in_s;
  logic [CW-1:0]     num_r, num_nx_s;
  logic [ADDR_W-1:0] x_r, x_nx_s;
  logic [ADDR_W-1:0] p_r, p_nx_s;
  logic [CW-1:0]     tgt_s;
  logic [INST_W-1:0] inst_r, inst_s;
  logic              busy_r, done_r;

  logic              x_cen_s, x_wen_s, p_cen_s, p_wen_s;
  logic [ADDR_W-1:0] x_a_s, p_a_s;
  logic              l0_rd_s, l0_wr_s, ofifo_rd_s, exec_s, load_s;

`ifdef CORE_SEQ_OS_EN
  assign mode_in_s = mode;
`else
  logic unused_mode_s;
  assign unused_mode_s = mode;
  assign mode_in_s     = 1'b0;
`endif

  assign tgt_s = mode_r ? ROW_C : num_r;

  // Next-state, counter and handshake sequencing.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    j_nx_s     = j_r;
    rd_nx_s    = 1'b0;
    wr_nx_s    = 1'b0;
    mode_nx_s  = mode_r;
    num_nx_s   = num_r;
    x_nx_s     = x_r;
    p_nx_s     = p_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          mode_nx_s  = mode_in_s;
          num_nx_s   = CW'(num_act);
          x_nx_s     = x_base;
          p_nx_s     = p_base;
          cnt_nx_s   = '0;
          j_nx_s     = '0;
          state_nx_s = mode_in_s ? EXEC : WLOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WLOAD: begin
        if (cnt_r == ROW_C) begin
          state_nx_s = KLOAD;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s   = cnt_r + ONE_C;
        end
      end
      KLOAD: begin
        if (cnt_r == KLAST_C) begin
          state_nx_s = EXEC;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s   = cnt_r + ONE_C;
        end
      end
      EXEC: begin
        if (cnt_r == num_r) begin
          state_nx_s = (tgt_s == '0) ? DONE : DRAIN;
          cnt_nx_s   = '0;
          j_nx_s     = '0;
        end else begin
          cnt_nx_s   = cnt_r + ONE_C;
        end
      end
      DRAIN: begin
        // A read is followed by its psum write; the final write closes the drain.
        if (wr_r && (j_r == tgt_s - ONE_C)) begin
          state_nx_s = DONE;
        end else begin
          rd_nx_s = ofifo_valid & ~rd_r;
          wr_nx_s = rd_r;
          j_nx_s  = wr_r ? (j_r + ONE_C) : j_r;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Instruction fields for the upcoming cycle, decoded from the next state.
  always_comb begin
    x_cen_s    = 1'b1;
    x_wen_s    = 1'b1;
    x_a_s      = ZERO_A;
    p_cen_s    = 1'b1;
    p_wen_s    = 1'b1;
    p_a_s      = ZERO_A;
    l0_rd_s    = 1'b0;
    l0_wr_s    = 1'b0;
    ofifo_rd_s = 1'b0;
    exec_s     = 1'b0;
    load_s     = 1'b0;
    case (state_nx_s)
      WLOAD: begin
        if (cnt_nx_s < ROW_C) begin
          x_cen_s = 1'b0;
          x_a_s   = x_nx_s + ADDR_W'(cnt_nx_s);
        end else begin
          x_cen_s = 1'b1;
        end
        l0_wr_s = (cnt_nx_s != '0);
      end
      KLOAD: begin
        l0_rd_s = 1'b1;
        load_s  = 1'b1;
      end
      EXEC: begin
        if (cnt_nx_s < num_nx_s) begin
          x_cen_s = 1'b0;
          x_a_s   = x_nx_s + (mode_nx_s ? ZERO_A : ROW_A) + ADDR_W'(cnt_nx_s);
        end else begin
          x_cen_s = 1'b1;
        end
        l0_wr_s = (cnt_nx_s != '0);
        l0_rd_s = (cnt_nx_s != '0);
        exec_s  = (cnt_nx_s != '0);
      end
      DRAIN: begin
        ofifo_rd_s = rd_nx_s;
        if (wr_nx_s) begin
          p_cen_s = 1'b0;
          p_wen_s = 1'b0;
          p_a_s   = p_nx_s + ADDR_W'(j_nx_s);
        end else begin
          p_cen_s = 1'b1;
        end
      end
      default: begin
        x_cen_s = 1'b1;
      end
    endcase
    inst_s = {mode_nx_s, p_cen_s, p_wen_s, p_a_s, x_cen_s, x_wen_s, x_a_s,
              1'b0, 1'b0, l0_rd_s, l0_wr_s, ofifo_rd_s, exec_s, load_s};
  end

  // State, counters, latched run parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      j_r     <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      mode_r  <= 1'b0;
      num_r   <= '0;
      x_r     <= ZERO_A;
      p_r     <= ZERO_A;
      inst_r  <= IDLE_WORD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      j_r     <= j_nx_s;
      rd_r    <= rd_nx_s;
      wr_r    <= wr_nx_s;
      mode_r  <= mode_nx_s;
      num_r   <= num_nx_s;
      x_r     <= x_nx_s;
      p_r     <= p_nx_s;
      inst_r  <= inst_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  assign inst = inst_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
